cmos_cmd_arbiter: RTL and testbench

Parametrised successor of the CMOS sensor command front-end. It arbitrates register-access requests from NUM_SRC sources, such as the power-up init table, the USB host and a runtime exposure/AGC controller. Each granted request becomes one SPI register transaction, either a write or a read. Read-back data is returned to the requester, and a timeout detects a hung SPI master. It sits between the command sources and the CMOS SPI master.

---
 rtl/cmos_cmd_pkg.sv | 21 ++
 rtl/cmos_cmd_rr_arb.sv | 43 ++++
 rtl/cmos_cmd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cmos_cmd_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cmd_pkg.sv
// Shared types and sizing helpers for the CMOS register-command arbiter.
// Holds the controller state encoding and the round-robin pointer width formula.
package cmos_cmd_pkg;

    typedef enum logic [2:0] {
        POWER_UP  = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        RESPOND   = 3'd5
    } cmos_cmd_state_t;

    localparam int MAX_SRC = 8;

    // A single source still needs a one-bit pointer so the vector is legal.
    function automatic int ptr_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/cmos_cmd_rr_arb.sv
// Combinational winner select: fixed lowest-index priority, or the first
// requester at or after the round-robin pointer, wrapping modulo NUM_SRC.
module cmos_cmd_rr_arb
    import cmos_cmd_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIXED_PRIO = 0,
    parameter int PTR_W      = ptr_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int base;
        int pos;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        base        = (FIXED_PRIO != 0) ? 0 : int'(ptr);
        if (base >= NUM_SRC) begin
            base = 0;
        end
        // Scan from the farthest offset down so the nearest requester is the last to write.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos = base + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            if (req[pos]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(pos);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cmos_cmd_arbiter.sv
// Arbitrates register-access requests from several sources onto one CMOS SPI
// master, returning read data and a timeout flag to the granted source.
module cmos_cmd_arbiter
    import cmos_cmd_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int TMO_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                      clk_input,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC-1:0]        src_wr,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    output logic [NUM_SRC-1:0]        src_ack,
    output logic [NUM_SRC-1:0]        src_done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic                      spi_idle,
    input  logic [DATA_W-1:0]         spi_rdata,
    output logic [ADDR_W-1:0]         spi_addr,
    output logic [DATA_W-1:0]         spi_wdata,
    output logic                      spi_wr,
    output logic                      spi_execute,
    output logic                      cmd_busy
);

    localparam int PTR_W = ptr_width(NUM_SRC);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

    cmos_cmd_state_t state_reg, state_next;

    logic [PTR_W-1:0]   ptr_reg;
    logic [NUM_SRC-1:0] owner_oh_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [ADDR_W-1:0]  spi_addr_reg;
    logic [DATA_W-1:0]  spi_wdata_reg;
    logic               spi_wr_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic               rsp_err_reg;
    logic               exec_reg;
    logic               busy_reg;

    logic [ADDR_W-1:0]  addr_arr  [NUM_SRC];
    logic [DATA_W-1:0]  wdata_arr [NUM_SRC];

    logic [NUM_SRC-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;

    logic capture;
    logic rd_capture;
    logic tmo_fire;
    logic in_wait;
    logic tmo_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign addr_arr[gi]  = src_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = src_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    cmos_cmd_rr_arb #(
        .NUM_SRC    (NUM_SRC),
        .FIXED_PRIO (FIXED_PRIO),
        .PTR_W      (PTR_W)
    ) u_arb (
        .req         (src_req),
        .ptr         (ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The count reaches its last value on the (2^TMO_W-1)th waiting cycle.
    assign tmo_hit = (tmo_cnt_reg >= TMO_LAST);

    always_ff @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= POWER_UP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            POWER_UP:  if (spi_idle) state_next = IDLE;
            IDLE:      if (grant_valid) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tmo_hit) begin
                    state_next = RESPOND;
                end else if (!spi_idle) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: if (spi_idle || tmo_hit) state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = POWER_UP;
        endcase
    end

    always_comb begin
        capture    = (state_reg == IDLE) && grant_valid;
        in_wait    = (state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE);
        rd_capture = (state_reg == WAIT_DONE) && spi_idle && !spi_wr_reg;
        // A real completion in WAIT_DONE wins over a timeout landing on the same cycle.
        tmo_fire   = ((state_reg == WAIT_BUSY) && tmo_hit) ||
                     ((state_reg == WAIT_DONE) && !spi_idle && tmo_hit);
        src_ack    = (state_reg == ISSUE)   ? owner_oh_reg : '0;
        src_done   = (state_reg == RESPOND) ? owner_oh_reg : '0;
    end

    always_ff @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg       <= '0;
            owner_oh_reg  <= '0;
            tmo_cnt_reg   <= '0;
            spi_addr_reg  <= '0;
            spi_wdata_reg <= '0;
            spi_wr_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            exec_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (capture) begin
                spi_addr_reg  <= addr_arr[grant_idx];
                spi_wdata_reg <= wdata_arr[grant_idx];
                spi_wr_reg    <= src_wr[grant_idx];
                owner_oh_reg  <= grant;
                rsp_err_reg   <= 1'b0;
                ptr_reg       <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            if (state_reg == ISSUE) begin
                tmo_cnt_reg <= '0;
            end else if (in_wait && (tmo_cnt_reg != TMO_MAX)) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
            if (rd_capture) begin
                rsp_rdata_reg <= spi_rdata;
            end
            if (tmo_fire) begin
                rsp_err_reg <= 1'b1;
            end
            // Registered so the start pulse trails the capture by two cycles.
            exec_reg <= (state_reg == ISSUE);
            busy_reg <= (state_next != IDLE);
        end
    end

    assign spi_addr    = spi_addr_reg;
    assign spi_wdata   = spi_wdata_reg;
    assign spi_wr      = spi_wr_reg;
    assign spi_execute = exec_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign cmd_busy    = busy_reg;

endmodule

// File: tb/tb_cmos_cmd_arbiter.sv
// Directed bench for cmos_cmd_arbiter: round-robin, fixed-priority and
// short-timeout instances driven from shared request stimulus.
module tb_cmos_cmd_arbiter;

    localparam int NS = 3;
    localparam int AW = 10;
    localparam int DW = 16;

    localparam int EV_ACK_A  = 0;
    localparam int EV_DONE_A = 1;
    localparam int EV_EXEC_A = 2;
    localparam int EV_ACK_T  = 3;
    localparam int EV_DONE_T = 4;
    localparam int EV_EXEC_T = 5;
    localparam int EV_BUSY_A = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [NS-1:0]    src_req;
    logic [NS-1:0]    src_wr;
    logic [NS*AW-1:0] src_addr;
    logic [NS*DW-1:0] src_wdata;
    logic             pu_idle;
    logic             model_idle;
    logic             spi_idle;
    logic [DW-1:0]    spi_rdata;
    logic             spi_idle_t;
    logic [DW-1:0]    spi_rdata_t;

    assign spi_idle = pu_idle & model_idle;

    logic [NS-1:0] ack_a, done_a, ack_f, done_f, ack_t, done_t;
    logic [DW-1:0] rdata_a, rdata_f, rdata_t, wdata_a, wdata_f, wdata_t;
    logic [AW-1:0] addr_a, addr_f, addr_t;
    logic          err_a, err_f, err_t, wr_a, wr_f, wr_t;
    logic          exec_a, exec_f, exec_t, busy_a, busy_f, busy_t;

    int n_vec = 0;
    int n_err = 0;
    int drop_dly = 3;
    int hold_dly = 20;
    logic [DW-1:0] model_rdata = '0;

    cmos_cmd_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .TMO_W(8), .FIXED_PRIO(0)) dut_a (
        .clk_input(clk), .reset_n(reset_n), .src_req(src_req), .src_wr(src_wr),
        .src_addr(src_addr), .src_wdata(src_wdata), .src_ack(ack_a), .src_done(done_a),
        .rsp_rdata(rdata_a), .rsp_err(err_a), .spi_idle(spi_idle), .spi_rdata(spi_rdata),
        .spi_addr(addr_a), .spi_wdata(wdata_a), .spi_wr(wr_a), .spi_execute(exec_a),
        .cmd_busy(busy_a));

    cmos_cmd_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .TMO_W(8), .FIXED_PRIO(1)) dut_f (
        .clk_input(clk), .reset_n(reset_n), .src_req(src_req), .src_wr(src_wr),
        .src_addr(src_addr), .src_wdata(src_wdata), .src_ack(ack_f), .src_done(done_f),
        .rsp_rdata(rdata_f), .rsp_err(err_f), .spi_idle(spi_idle), .spi_rdata(spi_rdata),
        .spi_addr(addr_f), .spi_wdata(wdata_f), .spi_wr(wr_f), .spi_execute(exec_f),
        .cmd_busy(busy_f));

    cmos_cmd_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .TMO_W(4), .FIXED_PRIO(0)) dut_t (
        .clk_input(clk), .reset_n(reset_n), .src_req(src_req), .src_wr(src_wr),
        .src_addr(src_addr), .src_wdata(src_wdata), .src_ack(ack_t), .src_done(done_t),
        .rsp_rdata(rdata_t), .rsp_err(err_t), .spi_idle(spi_idle_t), .spi_rdata(spi_rdata_t),
        .spi_addr(addr_t), .spi_wdata(wdata_t), .spi_wr(wr_t), .spi_execute(exec_t),
        .cmd_busy(busy_t));

    // SPI master model for dut_a/dut_f: idle drops drop_dly cycles after the
    // start pulse and rises hold_dly cycles later with the read data ready.
    initial begin
        model_idle = 1'b1;
        spi_rdata  = '0;
        forever begin
            @(negedge clk);
            if (exec_a) begin
                repeat (drop_dly) @(negedge clk);
                model_idle = 1'b0;
                spi_rdata  = model_rdata;
                repeat (hold_dly) @(negedge clk);
                model_idle = 1'b1;
            end
        end
    end

    function automatic logic pick(input int ev, input int s);
        case (ev)
            EV_ACK_A:  return ack_a[s];
            EV_DONE_A: return done_a[s];
            EV_EXEC_A: return exec_a;
            EV_ACK_T:  return ack_t[s];
            EV_DONE_T: return done_t[s];
            EV_EXEC_T: return exec_t;
            EV_BUSY_A: return !spi_idle;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int ev, input int s, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pick(ev, s)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_src(input int s, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_wr[s]            = wr;
        src_addr[s*AW +: AW] = a;
        src_wdata[s*DW +: DW] = d;
    endtask

    task automatic do_reset(input logic idle_after);
        @(negedge clk);
        reset_n = 1'b0;
        src_req = '0;
        repeat (3) @(negedge clk);
        pu_idle = idle_after;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pu_idle = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ack_a, done_a, exec_a, busy_a, err_a, wr_a} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ack=%b done=%b exec=%b busy=%b err=%b wr=%b, required all 0",
                     ack_a, done_a, exec_a, busy_a, err_a, wr_a);
        end
        n_vec++;
        if ({addr_a, wdata_a, rdata_a} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0", addr_a, wdata_a, rdata_a);
        end
    endtask

    task automatic test_power_up();
        int bad;
        bit ok;
        set_src(0, 1'b1, 10'h011, 16'h0011);
        src_req[0] = 1'b1;
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ack_a !== '0 || exec_a !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL pu_gating: %0d cycles with ack/execute, required 0", bad);
        end
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL pu_busy: got %b, required 1", busy_a);
        end
        pu_idle = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ack_a !== 3'b000 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL pu_idle_cycle: got ack=%b busy=%b, required ack=000 busy=0", ack_a, busy_a);
        end
        @(negedge clk);
        n_vec++;
        if (ack_a !== 3'b001 || exec_a !== 1'b0) begin
            n_err++;
            $display("FAIL pu_ack: got ack=%b exec=%b, required ack=001 exec=0", ack_a, exec_a);
        end
        src_req[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (exec_a !== 1'b1 || ack_a !== 3'b000) begin
            n_err++;
            $display("FAIL pu_exec: got exec=%b ack=%b, required exec=1 ack=000", exec_a, ack_a);
        end
        wait_ev(EV_DONE_A, 0, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL pu_done: got timeout, required src_done[0]");
        end
    endtask

    task automatic test_read();
        bit ok;
        model_rdata = 16'h1234;
        set_src(2, 1'b0, 10'h07F, 16'h0000);
        src_req[2] = 1'b1;
        wait_ev(EV_ACK_A, 2, ok);
        src_req[2] = 1'b0;
        n_vec++;
        if (!ok || addr_a !== 10'h07F || wr_a !== 1'b0) begin
            n_err++;
            $display("FAIL read_capture: got ok=%b addr=%h wr=%b, required ok=1 addr=07f wr=0", ok, addr_a, wr_a);
        end
        wait_ev(EV_DONE_A, 2, ok);
        n_vec++;
        if (!ok || done_a !== 3'b100 || rdata_a !== 16'h1234 || err_a !== 1'b0) begin
            n_err++;
            $display("FAIL read_done: got ok=%b done=%b rdata=%h err=%b, required done=100 rdata=1234 err=0",
                     ok, done_a, rdata_a, err_a);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (rdata_a !== 16'h1234 || done_a !== 3'b000) begin
            n_err++;
            $display("FAIL read_hold: got rdata=%h done=%b, required rdata=1234 done=000", rdata_a, done_a);
        end
    endtask

    task automatic test_write();
        bit ok;
        int cnt;
        logic err_seen;
        model_rdata = 16'hDEAD;
        set_src(1, 1'b1, 10'h04A, 16'hBEEF);
        src_req[1] = 1'b1;
        wait_ev(EV_ACK_A, 1, ok);
        src_req[1] = 1'b0;
        n_vec++;
        if (!ok || addr_a !== 10'h04A || wdata_a !== 16'hBEEF || wr_a !== 1'b1) begin
            n_err++;
            $display("FAIL write_capture: got ok=%b addr=%h wdata=%h wr=%b, required addr=04a wdata=beef wr=1",
                     ok, addr_a, wdata_a, wr_a);
        end
        cnt = 0;
        err_seen = 1'bx;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a[1]) begin
                cnt++;
                err_seen = err_a;
            end
        end
        n_vec++;
        if (cnt != 1 || err_seen !== 1'b0) begin
            n_err++;
            $display("FAIL write_done: got %0d done pulses err=%b, required 1 pulse err=0", cnt, err_seen);
        end
        n_vec++;
        if (rdata_a !== 16'h1234 || addr_a !== 10'h04A || wdata_a !== 16'hBEEF) begin
            n_err++;
            $display("FAIL write_hold: got rdata=%h addr=%h wdata=%h, required rdata=1234 addr=04a wdata=beef",
                     rdata_a, addr_a, wdata_a);
        end
    endtask

    task automatic test_round_robin();
        int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
        bit ok;
        do_reset(1'b1);
        drop_dly = 1;
        hold_dly = 2;
        set_src(0, 1'b1, 10'h100, 16'h1000);
        set_src(1, 1'b1, 10'h101, 16'h1001);
        set_src(2, 1'b1, 10'h102, 16'h1002);
        src_req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (ack_a !== '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_vec++;
            if (!ok || ack_a !== (3'b001 << exp_rr[g])) begin
                n_err++;
                $display("FAIL rr_grant%0d: got ack=%b, required source %0d", g, ack_a, exp_rr[g]);
            end
            n_vec++;
            if (ack_f !== 3'b001) begin
                n_err++;
                $display("FAIL fixed_grant%0d: got ack=%b, required 001", g, ack_f);
            end
        end
        src_req = '0;
        repeat (20) @(negedge clk);
        drop_dly = 3;
        hold_dly = 20;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        do_reset(1'b1);
        set_src(0, 1'b1, 10'h155, 16'h0F0F);
        src_req[0] = 1'b1;
        wait_ev(EV_ACK_A, 0, ok);
        src_req[0] = 1'b0;
        wait_ev(EV_BUSY_A, 0, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL abort_setup: got timeout, required spi idle drop");
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({ack_a, done_a, exec_a, busy_a, err_a, wr_a, addr_a, wdata_a, rdata_a} !== '0) begin
            n_err++;
            $display("FAIL abort_async: got ack=%b done=%b exec=%b busy=%b addr=%h wdata=%h, required all 0",
                     ack_a, done_a, exec_a, busy_a, addr_a, wdata_a);
        end
        pu_idle = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_src(1, 1'b0, 10'h0AA, 16'h0000);
        src_req[1] = 1'b1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_a !== '0 || ack_a !== '0 || exec_a !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL abort_powerup: got %0d active cycles busy=%b, required 0 and busy=1", bad, busy_a);
        end
        pu_idle = 1'b1;
        wait_ev(EV_ACK_A, 1, ok);
        src_req[1] = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL abort_resume: got timeout, required src_ack[1]");
        end
        wait_ev(EV_DONE_A, 1, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        spi_idle_t = 1'b1;
        do_reset(1'b1);
        set_src(2, 1'b0, 10'h033, 16'h0000);
        src_req[2] = 1'b1;
        wait_ev(EV_ACK_T, 2, ok);
        src_req[2] = 1'b0;
        wait_ev(EV_EXEC_T, 0, ok);
        spi_idle_t = 1'b0;
        repeat (3) @(negedge clk);
        spi_rdata_t = 16'hA5A5;
        spi_idle_t  = 1'b1;
        wait_ev(EV_DONE_T, 2, ok);
        n_vec++;
        if (!ok || rdata_t !== 16'hA5A5 || err_t !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_preread: got ok=%b rdata=%h err=%b, required rdata=a5a5 err=0", ok, rdata_t, err_t);
        end
        set_src(0, 1'b1, 10'h044, 16'h4444);
        src_req[0] = 1'b1;
        wait_ev(EV_ACK_T, 0, ok);
        src_req[0] = 1'b0;
        wait_ev(EV_EXEC_T, 0, ok);
        cnt = 0;
        while (!done_t[0] && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != 15 || err_t !== 1'b1 || rdata_t !== 16'hA5A5) begin
            n_err++;
            $display("FAIL tmo_fire: got %0d cycles err=%b rdata=%h, required 15 cycles err=1 rdata=a5a5",
                     cnt, err_t, rdata_t);
        end
        set_src(1, 1'b1, 10'h055, 16'h5555);
        src_req[1] = 1'b1;
        wait_ev(EV_ACK_T, 1, ok);
        src_req[1] = 1'b0;
        wait_ev(EV_EXEC_T, 0, ok);
        spi_idle_t = 1'b0;
        repeat (2) @(negedge clk);
        spi_idle_t = 1'b1;
        wait_ev(EV_DONE_T, 1, ok);
        n_vec++;
        if (!ok || err_t !== 1'b0 || rdata_t !== 16'hA5A5) begin
            n_err++;
            $display("FAIL tmo_recover: got ok=%b err=%b rdata=%h, required err=0 rdata=a5a5", ok, err_t, rdata_t);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        pu_idle     = 1'b0;
        src_req     = '0;
        src_wr      = '0;
        src_addr    = '0;
        src_wdata   = '0;
        spi_idle_t  = 1'b1;
        spi_rdata_t = '0;
        test_reset();
        test_power_up();
        test_read();
        test_write();
        test_round_robin();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
